program_loader: RTL
===================

# program_loader

Writes a program image into the instruction RAM, one 16-bit word per write, from a byte stream; it is the write side of the program memory that the CPU fetch logic reads. Sits between a byte source (UART receiver or debug port) and the RAM write port, and holds the CPU stalled while an image is being loaded. A load is framed as a 16-bit word count followed by that many big-endian words.

## Interface
- ADDR_WIDTH, 8, instruction RAM address width; the image holds at most 2^ADDR_WIDTH words.
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle pulse; begins a load. Honoured only in IDLE or ERROR.
- i_byte  input  8  incoming stream byte.
- i_byte_valid  input  1  i_byte is valid this cycle.
- o_byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when i_byte_valid && o_byte_ready.
- o_wr_en  output  1  RAM write strobe, one cycle per word.
- o_wr_addr  output  ADDR_WIDTH  RAM write address.
- o_wr_data  output  16  RAM write data, high byte received first.
- o_cpu_hold  output  1  CPU stall or reset request while loading.
- o_busy  output  1  load in progress (any state other than IDLE, DONE or ERROR).
- o_done  output  1  single-cycle pulse on successful completion.
- o_error  output  1  level; the last load failed.
- o_word_count  output  16  length header of the current or last load.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK (only with the checksum option), DONE, ERROR.
- IDLE: i_start goes to LEN_HI and clears o_error, the write address, the byte sum and o_word_count.
- LEN_HI, LEN_LO: accept the two length bytes, MSB first, into o_word_count (N).
- After LEN_LO:
  - N == 0 goes to CHECK if the option is compiled in, otherwise DONE.
  - N > 2^ADDR_WIDTH goes to ERROR.
  - Otherwise go to DATA_HI.
- DATA_HI, DATA_LO: accept the high byte, then the low byte, then go to WRITE.
- WRITE lasts exactly one cycle:
  - o_wr_en = 1, o_wr_addr = word index, o_wr_data = {hi, lo}.
  - The address then increments.
  - If the word just written was word N−1, go to CHECK or DONE; otherwise go to DATA_HI.
- DONE lasts one cycle: o_done = 1, then return to IDLE.
- ERROR holds until i_start (which restarts the load from LEN_HI) or i_reset.
- o_byte_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- o_cpu_hold = 1 in every state except IDLE and DONE, so it also stays high in ERROR to keep the CPU off a partial image.
- i_start outside IDLE and ERROR is ignored. i_byte_valid outside ready states is ignored, with no buffering.
- Write addresses run 0 to N−1 and never wrap, because N is bounded.

## Timing
- Reset values:
  - state = IDLE.
  - o_byte_ready, o_wr_en, o_cpu_hold, o_busy, o_done and o_error = 0.
  - o_wr_addr = 0, o_wr_data = 0, o_word_count = 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- i_start at edge k: o_busy, o_cpu_hold and o_byte_ready are high from k+1.
- Low data byte accepted at edge k: o_wr_en is high during cycle k+1 only, and o_byte_ready is low during that cycle.
- Peak throughput is 1 word per 3 cycles.
- Last write at cycle k (no checksum): o_done is high during cycle k+1, and o_cpu_hold falls in that same cycle.
- i_reset mid-load: the load aborts immediately and all outputs take their reset values. RAM contents written so far are left as-is.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The loader keeps an 8-bit running sum (mod 256) of all data bytes, excluding the length bytes.
  - After the last word it enters CHECK and accepts one trailing byte.
  - A match goes to DONE; a mismatch goes to ERROR.
- LOADER_CHECKSUM_EN undefined:
  - The CHECK state and the sum register do not exist.
  - The last write goes directly to DONE, and no trailing byte is consumed.

## Test plan
- Reset, then i_start; stream 00 02 12 34 AB CD with i_byte_valid held high -> writes 0x1234 at address 0 and 0xABCD at address 1, o_wr_en high for exactly 2 cycles, o_done one cycle after the second write, o_word_count = 2.
- Same stream with i_byte_valid toggled 1-0-1-0 -> identical writes, with no byte dropped or duplicated.
- Header 00 00 -> no o_wr_en pulses, o_done pulses (no-checksum build).
- Header 01 01 with ADDR_WIDTH = 8 -> ERROR, o_error = 1, o_cpu_hold = 1, o_byte_ready = 0; a following i_start clears o_error.
- Assert i_reset after the first data byte -> all outputs at reset values on the next cycle; a subsequent load of 00 01 55 AA writes 0x55AA at address 0.
- With LOADER_CHECKSUM_EN: 00 01 12 34 46 -> done; 00 01 12 34 47 -> error.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//
// Loads a program image into instruction RAM from a byte stream. A load is a
// 16-bit big-endian word count N followed by N big-endian 16-bit words. Each
// word is written to RAM in a dedicated one-cycle WRITE state at addresses
// 0..N-1. The CPU is held off the RAM for the whole load and stays held if
// the load fails.
//
// Build option: define LOADER_CHECKSUM_EN to append a trailing checksum byte
// (8-bit sum of all data bytes) that must match for the load to complete.
//
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_start              pulse, starts a load (from IDLE or ERROR only)
//   i_byte, i_byte_valid stream input; transfer on i_byte_valid && o_byte_ready
//   o_byte_ready         loader is in a byte-accepting state
//   o_wr_en, o_wr_addr,
//   o_wr_data            RAM write port, one strobe per word
//   o_cpu_hold           CPU stall while loading or after a failed load
//   o_busy               load in progress
//   o_done               one-cycle pulse on success
//   o_error              last load failed
//   o_word_count         length header of the current/last load
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_start
// LEN_HI   | accept high byte of word count
// LEN_LO   | accept low byte of word count, range-check it
// DATA_HI  | accept high byte of the next word
// DATA_LO  | accept low byte of the next word
// WRITE    | one-cycle RAM write, advance address
// CHECK    | accept and compare the checksum byte (checksum build only)
// DONE     | one-cycle completion pulse
// ERROR    | failed load, CPU kept held until restart or reset

module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [15:0]           o_word_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // Where a load goes once all words are written (or N == 0).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    // Largest legal word count; 17 bits so ADDR_WIDTH = 16 still fits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           len_d;
    logic                  last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
`endif

    // Full length as it will be once the low byte in LEN_LO is taken.
    assign len_d = {o_word_count[15:8], i_byte};

    // Address holds the index of the word being written; it is the last one
    // when index + 1 equals N. Widened so N = 2^ADDR_WIDTH compares correctly.
    assign last_word = ((17'(o_wr_addr) + 17'd1) == {1'b0, o_word_count});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (i_start) state_d = S_LEN_HI;
            S_LEN_HI:  if (i_byte_valid) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (i_byte_valid) begin
                    if (len_d == 16'd0) begin
                        state_d = S_FINISH;
                    end else if ({1'b0, len_d} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: if (i_byte_valid) state_d = S_DATA_LO;
            S_DATA_LO: if (i_byte_valid) state_d = S_WRITE;
            S_WRITE:   state_d = last_word ? S_FINISH : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_byte_valid) begin
                    state_d = (i_byte == sum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE:    state_d = S_IDLE;
            S_ERROR:   if (i_start) state_d = S_LEN_HI;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath. Byte-accepting states only ever see i_byte_valid here because
    // o_byte_ready is exactly the set of these states.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_ERROR: begin
                    if (i_start) begin
                        o_wr_addr    <= '0;
                        o_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q        <= '0;
`endif
                    end
                end
                S_LEN_HI: if (i_byte_valid) o_word_count[15:8] <= i_byte;
                S_LEN_LO: if (i_byte_valid) o_word_count[7:0]  <= i_byte;
                S_DATA_HI: begin
                    if (i_byte_valid) begin
                        o_wr_data[15:8] <= i_byte;
`ifdef LOADER_CHECKSUM_EN
                        sum_q           <= sum_q + i_byte;
`endif
                    end
                end
                S_DATA_LO: begin
                    if (i_byte_valid) begin
                        o_wr_data[7:0] <= i_byte;
`ifdef LOADER_CHECKSUM_EN
                        sum_q          <= sum_q + i_byte;
`endif
                    end
                end
                S_WRITE: o_wr_addr <= o_wr_addr + 1'b1;
                default: ;
            endcase
        end
    end

    // Control outputs are pure state decodes, so there is no input-to-output
    // combinational path.
    always_comb begin
        o_byte_ready = 1'b0;
        o_wr_en      = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        o_busy       = 1'b1;
        o_cpu_hold   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                o_busy     = 1'b0;
                o_cpu_hold = 1'b0;
            end
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: o_byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: o_byte_ready = 1'b1;
`endif
            S_WRITE: o_wr_en = 1'b1;
            S_DONE: begin
                o_done     = 1'b1;
                o_busy     = 1'b0;
                o_cpu_hold = 1'b0;
            end
            S_ERROR: begin
                o_error = 1'b1;
                o_busy  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
